// File: rtl/radar_sweep_sequencer_if.sv
// +-----------------------------------------------------------------------+
// | radar_sweep_sequencer_if                                              |
// | Servo, range-sensor, converter and point-output bundle of the         |
// | radar sweep sequencer.                                                |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

interface radar_sweep_sequencer_if;
  logic              enable;
  logic [3:0]        servo_theta;
  logic              meas_start;
  logic              meas_done;
  logic [7:0]        meas_range;
  logic [11:0]       r_theta;
  logic signed [8:0] conv_x;
  logic signed [8:0] conv_y;
  logic              point_valid;
  logic signed [8:0] point_x;
  logic signed [8:0] point_y;
  logic [3:0]        point_theta;
  logic              point_timeout;
  logic              sweep_done;

  modport master (
    input  enable, meas_done, meas_range, conv_x, conv_y,
    output servo_theta, meas_start, r_theta, point_valid, point_x, point_y,
           point_theta, point_timeout, sweep_done
  );

  modport slave (
    output enable, meas_done, meas_range, conv_x, conv_y,
    input  servo_theta, meas_start, r_theta, point_valid, point_x, point_y,
           point_theta, point_timeout, sweep_done
  );
endinterface

`default_nettype wire

// File: rtl/radar_sweep_sequencer.sv
// +-----------------------------------------------------------------------+
// | radar_sweep_sequencer                                                 |
// | Steps the servo through angle codes 0..MAX_THETA, triggers one range  |
// | measurement per angle and registers the converted x/y point.          |
// | Optional macro SWEEP_BOUNCE_EN: ping-pong sweep instead of wrap.      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module radar_sweep_sequencer #(
  parameter logic [23:0] SETTLE_CYCLES = 24'd2_700_000,
  parameter logic [23:0] MEAS_TIMEOUT  = 24'd1_620_000,
  parameter logic [3:0]  MAX_THETA     = 4'd12
) (
  input  wire logic               clock,
  input  wire logic               reset,
  radar_sweep_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_TRIGGER = 3'd2,
    ST_WAIT    = 3'd3,
    ST_CONVERT = 3'd4,
    ST_CAPTURE = 3'd5,
    ST_NEXT    = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [23:0]       cnt_q, cnt_d;
  logic [3:0]        servo_theta_q, servo_theta_d;
  logic [11:0]       r_theta_q, r_theta_d;
  logic              meas_start_q, meas_start_d;
  logic              point_valid_q, point_valid_d;
  logic signed [8:0] point_x_q, point_x_d;
  logic signed [8:0] point_y_q, point_y_d;
  logic [3:0]        point_theta_q, point_theta_d;
  logic              point_timeout_q, point_timeout_d;
  logic              sweep_done_q, sweep_done_d;
`ifdef SWEEP_BOUNCE_EN
  logic              dir_down_q, dir_down_d;
`endif

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    servo_theta_d   = servo_theta_q;
    r_theta_d       = r_theta_q;
    meas_start_d    = 1'b0;
    point_valid_d   = 1'b0;
    point_x_d       = point_x_q;
    point_y_d       = point_y_q;
    point_theta_d   = point_theta_q;
    point_timeout_d = point_timeout_q;
    sweep_done_d    = 1'b0;
`ifdef SWEEP_BOUNCE_EN
    dir_down_d      = dir_down_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.enable) begin
          state_d = ST_SETTLE;
          cnt_d   = 24'd0;
        end
      end

      ST_SETTLE: begin
        cnt_d = cnt_q + 24'd1;
        if (cnt_q == SETTLE_CYCLES - 24'd1) begin
          state_d      = ST_TRIGGER;
          meas_start_d = 1'b1;
        end
      end

      ST_TRIGGER: begin
        cnt_d   = 24'd0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (bus.meas_done) begin
          r_theta_d = {servo_theta_q, bus.meas_range};
          state_d   = ST_CONVERT;
        end else if (cnt_q == MEAS_TIMEOUT - 24'd1) begin
          point_timeout_d = 1'b1;
          state_d         = ST_NEXT;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end

      // Converter output has settled by the end of CONVERT; loading here
      // makes point_* and point_valid appear together during CAPTURE.
      ST_CONVERT: begin
        point_x_d       = bus.conv_x;
        point_y_d       = bus.conv_y;
        point_theta_d   = servo_theta_q;
        point_valid_d   = 1'b1;
        point_timeout_d = 1'b0;
        state_d         = ST_CAPTURE;
      end

      ST_CAPTURE: begin
        state_d = ST_NEXT;
      end

      ST_NEXT: begin
`ifdef SWEEP_BOUNCE_EN
        if (dir_down_q) begin
          if (servo_theta_q == 4'd0) begin
            sweep_done_d  = 1'b1;
            dir_down_d    = 1'b0;
            servo_theta_d = 4'd1;
          end else begin
            servo_theta_d = servo_theta_q - 4'd1;
          end
        end else if (servo_theta_q == MAX_THETA) begin
          sweep_done_d  = 1'b1;
          dir_down_d    = 1'b1;
          servo_theta_d = MAX_THETA - 4'd1;
        end else begin
          servo_theta_d = servo_theta_q + 4'd1;
        end
`else
        if (servo_theta_q == MAX_THETA) begin
          sweep_done_d  = 1'b1;
          servo_theta_d = 4'd0;
        end else begin
          servo_theta_d = servo_theta_q + 4'd1;
        end
`endif
        cnt_d   = 24'd0;
        state_d = bus.enable ? ST_SETTLE : ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      cnt_q           <= 24'd0;
      servo_theta_q   <= 4'd0;
      r_theta_q       <= 12'd0;
      meas_start_q    <= 1'b0;
      point_valid_q   <= 1'b0;
      point_x_q       <= 9'sd0;
      point_y_q       <= 9'sd0;
      point_theta_q   <= 4'd0;
      point_timeout_q <= 1'b0;
      sweep_done_q    <= 1'b0;
`ifdef SWEEP_BOUNCE_EN
      dir_down_q      <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      servo_theta_q   <= servo_theta_d;
      r_theta_q       <= r_theta_d;
      meas_start_q    <= meas_start_d;
      point_valid_q   <= point_valid_d;
      point_x_q       <= point_x_d;
      point_y_q       <= point_y_d;
      point_theta_q   <= point_theta_d;
      point_timeout_q <= point_timeout_d;
      sweep_done_q    <= sweep_done_d;
`ifdef SWEEP_BOUNCE_EN
      dir_down_q      <= dir_down_d;
`endif
    end
  end

  assign bus.servo_theta   = servo_theta_q;
  assign bus.meas_start    = meas_start_q;
  assign bus.r_theta       = r_theta_q;
  assign bus.point_valid   = point_valid_q;
  assign bus.point_x       = point_x_q;
  assign bus.point_y       = point_y_q;
  assign bus.point_theta   = point_theta_q;
  assign bus.point_timeout = point_timeout_q;
  assign bus.sweep_done    = sweep_done_q;

endmodule

`default_nettype wire

// File: tb/tb_radar_sweep_sequencer.sv
// +-----------------------------------------------------------------------+
// | tb_radar_sweep_sequencer                                              |
// | Scoreboard bench: sensor responder queues expected points, monitors   |
// | compare against point_valid / meas_start / sweep_done.                |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_radar_sweep_sequencer;

  typedef struct {
    logic [3:0] theta;
    logic [7:0] range;
    bit         withhold;
    int         delay;
    bit         tflag;
    logic [8:0] ex;
    logic [8:0] ey;
  } act_t;

  typedef struct {
    logic [3:0] theta;
    logic [7:0] range;
    logic [8:0] ex;
    logic [8:0] ey;
    int         stamp;
  } pt_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   sd_cnt = 0;
  bit   idle_req = 1'b0;

  act_t       act_q[$];
  pt_t        pt_q[$];
  logic [3:0] sd_q[$];

  radar_sweep_sequencer_if bus();

  radar_sweep_sequencer #(
    .SETTLE_CYCLES (24'd4),
    .MEAS_TIMEOUT  (24'd8),
    .MAX_THETA     (4'd12)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Converter model: two hand-computed vectors, otherwise x=r, y=theta.
  always_comb begin
    case (bus.r_theta)
      12'h2C8: begin bus.conv_x = 9'd173;  bus.conv_y = 9'd100; end
      12'h964: begin bus.conv_x = 9'h1BA;  bus.conv_y = 9'd70;  end
      default: begin
        bus.conv_x = {1'b0, bus.r_theta[7:0]};
        bus.conv_y = {5'b0, bus.r_theta[11:8]};
      end
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_servo_theta"},   {28'd0, bus.servo_theta}, 32'd0);
    chk({tag, "_r_theta"},       {20'd0, bus.r_theta},     32'd0);
    chk({tag, "_point_x"},       {23'd0, bus.point_x},     32'd0);
    chk({tag, "_point_y"},       {23'd0, bus.point_y},     32'd0);
    chk({tag, "_point_theta"},   {28'd0, bus.point_theta}, 32'd0);
    chk({tag, "_ctrl_pulses"},
        {28'd0, bus.meas_start, bus.point_valid, bus.point_timeout, bus.sweep_done}, 32'd0);
  endtask

  task automatic push_act(input logic [3:0] t, input bit wh, input int dly, input bit tf);
    act_t a;
    a.theta    = t;
    a.withhold = wh;
    a.delay    = dly;
    a.tflag    = tf;
    if (t == 4'd2) begin
      a.range = 8'd200; a.ex = 9'd173; a.ey = 9'd100;
    end else if (t == 4'd9) begin
      a.range = 8'd100; a.ex = 9'h1BA; a.ey = 9'd70;
    end else begin
      a.range = 8'(16 * int'(t) + 3);
      a.ex    = {1'b0, a.range};
      a.ey    = {5'b0, t};
    end
    act_q.push_back(a);
  endtask

  // Range sensor: answers each meas_start after a per-measurement delay.
  initial begin
    int   pend;
    int   idle_sent;
    act_t cur;
    pt_t  p;
    pend = 0;
    idle_sent = 0;
    bus.meas_done  = 1'b0;
    bus.meas_range = 8'd0;
    forever begin
      @(negedge clock);
      bus.meas_done = 1'b0;
      if (reset) begin
        pend = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            bus.meas_done  = 1'b1;
            bus.meas_range = cur.range;
            p.theta = cur.theta;
            p.range = cur.range;
            p.ex    = cur.ex;
            p.ey    = cur.ey;
            p.stamp = cyc;
            pt_q.push_back(p);
          end
        end else if (idle_req && idle_sent < 3) begin
          idle_sent++;
          bus.meas_done  = 1'b1;
          bus.meas_range = 8'h55;
        end
        if (bus.meas_start) begin
          total++;
          if (act_q.size() == 0) begin
            bad++;
            $display("FAIL meas_start_unexpected: got theta %0d expected no measurement", bus.servo_theta);
          end else begin
            cur = act_q.pop_front();
            chk("meas_theta", {28'd0, bus.servo_theta}, {28'd0, cur.theta});
            chk("timeout_flag_at_start", {31'd0, bus.point_timeout}, {31'd0, cur.tflag});
            if (!cur.withhold) pend = cur.delay;
          end
        end
      end
    end
  end

  // Point monitor.
  initial begin
    pt_t p;
    forever begin
      @(negedge clock);
      if (!reset && bus.point_valid) begin
        total++;
        if (pt_q.size() == 0) begin
          bad++;
          $display("FAIL point_unexpected: got theta %0d expected no point", bus.point_theta);
        end else begin
          p = pt_q.pop_front();
          chk("point_x",       {23'd0, bus.point_x},     {23'd0, p.ex});
          chk("point_y",       {23'd0, bus.point_y},     {23'd0, p.ey});
          chk("point_theta",   {28'd0, bus.point_theta}, {28'd0, p.theta});
          chk("point_timeout", {31'd0, bus.point_timeout}, 32'd0);
          chk("r_theta",       {20'd0, bus.r_theta},     {20'd0, p.theta, p.range});
          chk("done_to_valid", cyc - p.stamp, 32'd2);
        end
      end
    end
  end

  // Sweep-end monitor: servo angle already stepped when sweep_done shows.
  initial begin
    logic [3:0] e;
    forever begin
      @(negedge clock);
      if (!reset && bus.sweep_done) begin
        sd_cnt++;
        total++;
        if (sd_q.size() == 0) begin
          bad++;
          $display("FAIL sweep_done_unexpected: got theta %0d expected no pulse", bus.servo_theta);
        end else begin
          e = sd_q.pop_front();
          chk("sweep_done_theta", {28'd0, bus.servo_theta}, {28'd0, e});
        end
      end
    end
  end

  initial begin
    int t0;
    int k;
    bus.enable = 1'b0;
    repeat (3) @(negedge clock);
    chk_zero("reset_init");
    reset = 1'b0;

    // Phase A: run to theta 5, hold its measurement, reset mid-WAIT.
    for (int t = 0; t <= 5; t++) push_act(4'(t), t == 5, (t % 3) + 1, 1'b0);
    @(negedge clock);
    bus.enable = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (act_q.size() == 0) break;
    end
    chk("phaseA_reached_theta5", act_q.size(), 32'd0);
    repeat (3) @(negedge clock);
    chk("pre_reset_point_theta", {28'd0, bus.point_theta}, 32'd4);
    chk("pre_reset_servo",       {28'd0, bus.servo_theta}, 32'd5);
    #2 reset = 1'b1;
    #1 chk_zero("reset_async");
    bus.enable = 1'b0;
    chk("phaseA_points_drained", pt_q.size(), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Phase B: full sweep, then a partial pass ending at theta 7.
    k = 0;
    for (int t = 0; t <= 12; t++) begin
      push_act(4'(t), k == 4, (k == 3) ? 8 : (k % 3) + 1, k == 5);
      k++;
    end
`ifdef SWEEP_BOUNCE_EN
    for (int t = 11; t >= 0; t--) begin
      push_act(4'(t), 1'b0, (k % 3) + 1, 1'b0);
      k++;
    end
    for (int t = 1; t <= 7; t++) begin
      push_act(4'(t), 1'b0, (k % 3) + 1, 1'b0);
      k++;
    end
    sd_q.push_back(4'd11);
    sd_q.push_back(4'd1);
`else
    for (int t = 0; t <= 7; t++) begin
      push_act(4'(t), 1'b0, (k % 3) + 1, 1'b0);
      k++;
    end
    sd_q.push_back(4'd0);
`endif

    @(negedge clock);
    bus.enable = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus.meas_start) break;
    end
    chk("first_start_latency", cyc - t0, 32'd5);
    chk("first_start_theta",   {28'd0, bus.servo_theta}, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (act_q.size() == 1 && bus.servo_theta == 4'd7) break;
    end
    chk("reached_final_settle7", act_q.size(), 32'd1);
    bus.enable = 1'b0;

    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (act_q.size() == 0 && pt_q.size() == 0) break;
    end
    repeat (20) @(negedge clock);
    chk("final_points_drained", pt_q.size(), 32'd0);
    chk("idle_servo_theta",     {28'd0, bus.servo_theta}, 32'd8);
`ifdef SWEEP_BOUNCE_EN
    chk("sweep_done_count", sd_cnt, 32'd2);
`else
    chk("sweep_done_count", sd_cnt, 32'd1);
`endif

    idle_req = 1'b1;
    repeat (12) @(negedge clock);
    chk("idle_r_theta_held",     {20'd0, bus.r_theta},     32'h773);
    chk("idle_point_theta_held", {28'd0, bus.point_theta}, 32'd7);
    chk("idle_servo_held",       {28'd0, bus.servo_theta}, 32'd8);
    chk("idle_no_extra_meas",    act_q.size(),             32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/radar_sweep_sequencer.md
Name: radar_sweep_sequencer

Overview:
- Sequences the radar sweep: steps the servo through the 13 angle codes (theta 0..12 = 0..180 deg in 15 deg steps) and waits for servo settle.
- Triggers one range measurement per angle and drives the packed r_theta word into the shared polar-to-Cartesian converter.
- Registers the signed x/y result as one point per angle for the display and guidance logic.

Parameters:
- SETTLE_CYCLES, 24'd2_700_000, clock cycles to wait after every servo angle change (100 ms at 27 MHz).
- MEAS_TIMEOUT, 24'd1_620_000, max cycles to wait for meas_done before the angle is abandoned.
- MAX_THETA, 4'd12, highest angle code; must be <= 12.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  level; sweep runs while high
- servo_theta  out  4  commanded angle code to servo driver
- meas_start  out  1  one-cycle pulse requesting a range measurement
- meas_done  in  1  one-cycle pulse, range sensor finished
- meas_range  in  8  range, valid in the meas_done cycle
- r_theta  out  12  to converter: [11:8] theta, [7:0] r
- conv_x  in  9  signed x from converter (combinational)
- conv_y  in  9  signed y from converter (combinational)
- point_valid  out  1  one-cycle pulse, new point on point_* outputs
- point_x  out  9  signed registered x
- point_y  out  9  signed registered y
- point_theta  out  4  angle code of the point
- point_timeout  out  1  sticky-per-angle: last angle timed out; cleared at next point_valid
- sweep_done  out  1  one-cycle pulse when an end of the sweep is reached

Behaviour:
- Reset (async, active-high): state IDLE; servo_theta=0; r_theta=0; point_x/point_y/point_theta=0; meas_start, point_valid, point_timeout, sweep_done=0; settle/timeout counter=0; direction=up.
- Clock/reset: single clock; all state changes on the rising edge; reset asserted asynchronously.
- IDLE: while enable=0 hold all outputs. On enable=1 -> SETTLE; counter loads 0.
- SETTLE:
  - Counter increments each cycle.
  - At counter==SETTLE_CYCLES-1 -> TRIGGER.
  - enable dropping in any non-IDLE state: finish the current state, then return to IDLE at the next NEXT state (no truncated points).
- TRIGGER: meas_start=1 for exactly this cycle; counter cleared; -> WAIT.
- WAIT:
  - meas_done=1: latch meas_range into r_theta[7:0]; r_theta[11:8]=servo_theta; -> CONVERT.
  - Counter reaches MEAS_TIMEOUT-1 without meas_done: point_timeout=1; no point emitted; -> NEXT.
  - meas_done arriving in any state other than WAIT is ignored.
- CONVERT: one cycle for converter settling; r_theta held stable; -> CAPTURE.
- CAPTURE: point_x<=conv_x; point_y<=conv_y; point_theta<=servo_theta; point_valid=1 for this cycle; point_timeout<=0; -> NEXT.
- NEXT: compute next angle.
  - Up: if servo_theta==MAX_THETA, sweep_done pulses and the angle wraps (see Optional Feature); else +1.
  - Down (bounce only): if servo_theta==0, sweep_done pulses and direction flips to up, next angle 1; else -1.
  - Then -> IDLE if enable=0, else -> SETTLE.
- Latency:
  - meas_done to point_valid: 2 cycles (CONVERT, CAPTURE).
  - Angle step to meas_start: SETTLE_CYCLES+1 cycles.
- Width rules: counter 24 bits unsigned; r_theta[11:8] never exceeds MAX_THETA; range passes through unmodified.
- Async reset mid-sweep: returns immediately to the reset state; the servo is commanded to angle 0.

Optional Feature:
- Macro SWEEP_BOUNCE_EN.
- Defined: at MAX_THETA, direction flips to down and the next angle is MAX_THETA-1. The sweep ping-pongs 0..12..0 and sweep_done pulses at each end.
- Undefined: direction is always up; after MAX_THETA the next angle is 0 and sweep_done pulses once per wrap. The servo traverses back in a single SETTLE period.

Test Plan (SETTLE_CYCLES=4, MEAS_TIMEOUT=8 for sim):
- Reset asserted mid-WAIT at theta=5 -> all outputs zero immediately (asynchronous); after release, with enable=1, the first meas_start occurs at theta=0 after 4 settle cycles.
- Theta=2, meas_done with range=200, model converter returns x=173, y=100 -> r_theta=12'h2C8; point_valid exactly 2 cycles later; point_x=173, point_y=100, point_theta=2.
- Theta=9, range=100, converter x=-70 -> point_x=9'h1BA, point_y=70.
- meas_done withheld 8 cycles at theta=4 -> no point_valid; point_timeout=1; next meas_start at theta=5; timeout flag clears on the next point.
- Full sweep, bounce undefined -> theta sequence 0..12,0 with sweep_done once after 12; bounce defined -> 0..12,11..0,1, with sweep_done after 12 and after 0.
- enable dropped during SETTLE at theta=7 -> exactly one more point (theta=7); then IDLE with servo_theta=8 held; meas_done pulses in IDLE are ignored.
